// File: rtl/tts_pkg.sv
// Shared types and constants for the host-side symbol-parameter RAM write sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tts_pkg;

    // Write sequencer states: idle, request held, one-cycle release gap.
    typedef enum logic [1:0] {
        HPB_IDLE = 2'd0,
        HPB_REQ  = 2'd1,
        HPB_REL  = 2'd2
    } hpb_state_t;

    // Host register word offsets.
    localparam logic [3:0] HPB_REG_CTRL     = 4'd0;
    localparam logic [3:0] HPB_REG_STATUS   = 4'd1;
    localparam logic [3:0] HPB_REG_SYM_ADDR = 4'd2;
    localparam logic [3:0] HPB_REG_BYTE_EN  = 4'd3;
    localparam logic [3:0] HPB_REG_DATA0    = 4'd4;

    // CTRL bit positions.
    localparam int HPB_CTRL_GO      = 0;
    localparam int HPB_CTRL_CLR_ERR = 1;

    // STATUS bit positions.
    localparam int HPB_STAT_BUSY    = 0;
    localparam int HPB_STAT_ERR     = 1;
    localparam int HPB_STAT_COLL    = 2;
    localparam int HPB_STAT_CNT_LSB = 16;

endpackage

// File: rtl/hpb_wr_ctrl.sv
// Host register file that issues one RAM write per GO and holds the request until done or timeout.
// Latency: register write/read 1 cycle; GO to hpb_wr_req 1 cycle; done to release 1 cycle, idle 1 cycle later.
// Backpressure: request held while rcb_wr_done is low (bounded by HPB_TIMEOUT); host writes to payload registers while busy are dropped and flagged.
module hpb_wr_ctrl
    import tts_pkg::*;
#(
    parameter int HPB_RAM_WIDTH = 64,
    parameter int HPB_TIMEOUT   = 1024,
    parameter bit HPB_AUTO_INC  = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       host_cs,
    input  logic                       host_we,
    input  logic [3:0]                 host_addr,
    input  logic [31:0]                host_wdata,
    output logic [31:0]                host_rdata,
    output logic                       host_rvalid,
    output logic [13:0]                hpb_wr_addr,
    output logic [HPB_RAM_WIDTH-1:0]   hpb_wr_data,
    output logic [HPB_RAM_WIDTH/8-1:0] hpb_wr_en,
    output logic                       hpb_wr_req,
    input  logic                       rcb_wr_done,
    output logic                       hpb_busy,
    output logic                       hpb_err
);

    localparam int NW = HPB_RAM_WIDTH / 32;
    localparam int NB = HPB_RAM_WIDTH / 8;
    localparam int TW = $clog2(HPB_TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(HPB_TIMEOUT - 1);

    hpb_state_t           state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [15:0]          wr_count_q, wr_count_d;
    logic [13:0]          sym_addr_q, sym_addr_d;
    logic [NB-1:0]        byte_en_q, byte_en_d;
    logic [NW-1:0][31:0]  data_q, data_d;
    logic                 err_q, err_d;
    logic                 coll_q, coll_d;
    logic                 req_q, req_d;
    logic                 busy_q, busy_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic [31:0]          rd_mux;
    logic                 go;

    logic host_wr;
    logic host_rd;
    logic busy;

    assign host_wr = host_cs & host_we;
    assign host_rd = host_cs & ~host_we;
    assign busy    = (state_q != HPB_IDLE);

    // Read-data select for the addressed register; unmapped words read as zero.
    always_comb begin
        rd_mux = '0;
        case (host_addr)
            HPB_REG_STATUS: begin
                rd_mux[HPB_STAT_BUSY]           = busy;
                rd_mux[HPB_STAT_ERR]            = err_q;
                rd_mux[HPB_STAT_COLL]           = coll_q;
                rd_mux[HPB_STAT_CNT_LSB +: 16]  = wr_count_q;
            end
            HPB_REG_SYM_ADDR: rd_mux[13:0]   = sym_addr_q;
            HPB_REG_BYTE_EN:  rd_mux[NB-1:0] = byte_en_q;
            default: ;
        endcase
        for (int i = 0; i < NW; i++) begin
            if (host_addr == HPB_REG_DATA0 + 4'(i)) begin
                rd_mux = data_q[i];
            end
        end
    end

    // Next-state: host register accesses, then the write FSM and its timeout timer.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        wr_count_d = wr_count_q;
        sym_addr_d = sym_addr_q;
        byte_en_d  = byte_en_q;
        data_d     = data_q;
        err_d      = err_q;
        coll_d     = coll_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        go         = 1'b0;

        if (host_rd) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end

        if (host_wr) begin
            if (host_addr == HPB_REG_CTRL) begin
                // Clear first so that CLR_ERR+GO in one write starts a request.
                if (host_wdata[HPB_CTRL_CLR_ERR]) begin
                    err_d  = 1'b0;
                    coll_d = 1'b0;
                end
                if (host_wdata[HPB_CTRL_GO]) begin
                    if (busy) begin
                        coll_d = 1'b1;
                    end else if (!err_d) begin
                        go = 1'b1;
                    end
                end
            end else if (host_addr == HPB_REG_SYM_ADDR) begin
                if (busy) coll_d = 1'b1;
                else      sym_addr_d = host_wdata[13:0];
            end else if (host_addr == HPB_REG_BYTE_EN) begin
                if (busy) coll_d = 1'b1;
                else      byte_en_d = host_wdata[NB-1:0];
            end
            for (int i = 0; i < NW; i++) begin
                if (host_addr == HPB_REG_DATA0 + 4'(i)) begin
                    if (busy) coll_d = 1'b1;
                    else      data_d[i] = host_wdata;
                end
            end
        end

        case (state_q)
            HPB_IDLE: begin
                timer_d = '0;
                if (go) state_d = HPB_REQ;
            end
            HPB_REQ: begin
                if (rcb_wr_done) begin
                    state_d    = HPB_REL;
                    timer_d    = '0;
                    wr_count_d = wr_count_q + 16'd1;
                    if (HPB_AUTO_INC) sym_addr_d = sym_addr_q + 14'd1;
                end else if (timer_q == TMAX) begin
                    // Timeout wins over a simultaneous CLR_ERR so the failure is never lost.
                    state_d = HPB_REL;
                    timer_d = '0;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            HPB_REL: begin
                timer_d = '0;
                state_d = HPB_IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = HPB_IDLE;
            end
        endcase

        req_d  = (state_d == HPB_REQ);
        busy_d = (state_d != HPB_IDLE);
    end

    // State and register-file update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= HPB_IDLE;
            timer_q    <= '0;
            wr_count_q <= '0;
            sym_addr_q <= '0;
            byte_en_q  <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            coll_q     <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            wr_count_q <= wr_count_d;
            sym_addr_q <= sym_addr_d;
            byte_en_q  <= byte_en_d;
            data_q     <= data_d;
            err_q      <= err_d;
            coll_q     <= coll_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign host_rdata  = rdata_q;
    assign host_rvalid = rvalid_q;
    assign hpb_wr_addr = sym_addr_q;
    assign hpb_wr_data = data_q;
    assign hpb_wr_en   = byte_en_q;
    assign hpb_wr_req  = req_q;
    assign hpb_busy    = busy_q;
    assign hpb_err     = err_q;

endmodule

// File: tb/tb_hpb_wr_ctrl.sv
// Directed bench for hpb_wr_ctrl: register table plus multi-cycle request sequences.
// Latency: n/a.
// Backpressure: done is driven per test to stall, complete or time out requests.
module tb_hpb_wr_ctrl;
    import tts_pkg::*;

    localparam int W  = 64;
    localparam int NB = W / 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          host_cs, host_we;
    logic [3:0]    host_addr;
    logic [31:0]   host_wdata;
    logic [31:0]   host_rdata, host_rdata2;
    logic          host_rvalid, host_rvalid2;
    logic [13:0]   hpb_wr_addr, hpb_wr_addr2;
    logic [W-1:0]  hpb_wr_data, hpb_wr_data2;
    logic [NB-1:0] hpb_wr_en, hpb_wr_en2;
    logic          hpb_wr_req, hpb_wr_req2;
    logic          rcb_wr_done, rcb_wr_done2;
    logic          hpb_busy, hpb_busy2;
    logic          hpb_err, hpb_err2;

    int checks = 0;
    int errors = 0;
    int h, r, seen;
    logic [31:0] rd, rd2;

    always #5 clk = ~clk;

    hpb_wr_ctrl #(.HPB_RAM_WIDTH(W), .HPB_TIMEOUT(8), .HPB_AUTO_INC(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .host_cs(host_cs), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .hpb_wr_addr(hpb_wr_addr), .hpb_wr_data(hpb_wr_data),
        .hpb_wr_en(hpb_wr_en), .hpb_wr_req(hpb_wr_req), .rcb_wr_done(rcb_wr_done),
        .hpb_busy(hpb_busy), .hpb_err(hpb_err)
    );

    // Second instance without address auto-increment; its done follows its own request.
    assign rcb_wr_done2 = hpb_wr_req2;
    hpb_wr_ctrl #(.HPB_RAM_WIDTH(W), .HPB_TIMEOUT(8), .HPB_AUTO_INC(1'b0)) u_dut_noinc (
        .clk(clk), .reset_n(reset_n), .host_cs(host_cs), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata2),
        .host_rvalid(host_rvalid2), .hpb_wr_addr(hpb_wr_addr2), .hpb_wr_data(hpb_wr_data2),
        .hpb_wr_en(hpb_wr_en2), .hpb_wr_req(hpb_wr_req2), .rcb_wr_done(rcb_wr_done2),
        .hpb_busy(hpb_busy2), .hpb_err(hpb_err2)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [3:0] a, input logic [31:0] d);
        host_cs = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        @(posedge clk); #1;
        host_cs = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_read(input logic [3:0] a);
        host_cs = 1'b1; host_we = 1'b0; host_addr = a;
        @(posedge clk); #1;
        host_cs = 1'b0;
        rd  = host_rdata;
        rd2 = host_rdata2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Runs the current request to idle; done is raised once done_after request cycles
    // have passed (negative: never). Returns request-high and release cycle counts.
    task automatic measure(input int done_after, output int high, output int rel);
        bit fin;
        fin = 1'b0; high = 0; rel = 0;
        for (int i = 0; i < 64 && !fin; i++) begin
            if (!hpb_busy) begin
                fin = 1'b1;
            end else begin
                if (hpb_wr_req) begin
                    rcb_wr_done = (done_after >= 0) && (high >= done_after);
                    high++;
                end else begin
                    rcb_wr_done = 1'b0;
                    rel++;
                end
                @(posedge clk); #1;
            end
        end
        rcb_wr_done = 1'b0;
        check("idle_within_budget", 64'(fin), 64'd1);
    endtask

    task automatic count_req(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (hpb_wr_req) n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        host_cs = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        rcb_wr_done = 1'b0;
        do_reset();

        check("reset_req",    64'(hpb_wr_req),  64'd0);
        check("reset_busy",   64'(hpb_busy),    64'd0);
        check("reset_err",    64'(hpb_err),     64'd0);
        check("reset_rvalid", 64'(host_rvalid), 64'd0);
        check("reset_rdata",  64'(host_rdata),  64'd0);
        check("reset_wdata",  64'(hpb_wr_data), 64'd0);

        vecs[0] = '{HPB_REG_STATUS,   32'hFFFF_FFFF, 32'h0000_0000};
        vecs[1] = '{HPB_REG_SYM_ADDR, 32'hFFFF_0123, 32'h0000_0123};
        vecs[2] = '{HPB_REG_BYTE_EN,  32'h1234_56A5, 32'h0000_00A5};
        vecs[3] = '{4'd4,             32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[4] = '{4'd5,             32'h0123_4567, 32'h0123_4567};
        vecs[5] = '{4'd6,             32'hCAFE_F00D, 32'h0000_0000};
        vecs[6] = '{4'd15,            32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7] = '{HPB_REG_CTRL,     32'h0000_0000, 32'h0000_0000};
        for (int i = 0; i < 8; i++) begin
            host_write(vecs[i].addr, vecs[i].wdata);
            host_read(vecs[i].addr);
            check($sformatf("regfile_rdata[%0d]", i), 64'(rd), 64'(vecs[i].exp));
            check($sformatf("regfile_rvalid[%0d]", i), 64'(host_rvalid), 64'd1);
        end
        @(posedge clk); #1;
        check("rvalid_pulse_drops", 64'(host_rvalid), 64'd0);

        // Single write, done returned in the first request cycle.
        host_write(HPB_REG_BYTE_EN, 32'h0000_00FF);
        host_write(HPB_REG_CTRL, 32'h1);
        check("go_req",      64'(hpb_wr_req),  64'd1);
        check("go_busy",     64'(hpb_busy),    64'd1);
        check("single_data", hpb_wr_data,      64'h0123_4567_DEAD_BEEF);
        check("single_addr", 64'(hpb_wr_addr), 64'h123);
        check("single_en",   64'(hpb_wr_en),   64'hFF);
        measure(0, h, r);
        check("single_req_cycles", 64'(h), 64'd1);
        check("single_rel_cycles", 64'(r), 64'd1);
        host_read(HPB_REG_STATUS);
        check("single_status", 64'(rd), 64'h0001_0000);
        host_read(HPB_REG_SYM_ADDR);
        check("single_symaddr", 64'(rd), 64'h124);

        // Stalled done: five waiting cycles, then done.
        host_write(HPB_REG_CTRL, 32'h1);
        measure(5, h, r);
        check("stall_req_cycles", 64'(h), 64'd6);
        check("stall_rel_cycles", 64'(r), 64'd1);
        check("stall_err", 64'(hpb_err), 64'd0);
        host_read(HPB_REG_STATUS);
        check("stall_status", 64'(rd), 64'h0002_0000);

        // Timeout with done never returned.
        do_reset();
        host_write(HPB_REG_CTRL, 32'h1);
        measure(-1, h, r);
        check("timeout_req_cycles", 64'(h), 64'd8);
        check("timeout_rel_cycles", 64'(r), 64'd1);
        check("timeout_err", 64'(hpb_err), 64'd1);
        host_read(HPB_REG_STATUS);
        check("timeout_status", 64'(rd), 64'h0000_0002);
        host_read(HPB_REG_SYM_ADDR);
        check("timeout_symaddr", 64'(rd), 64'h0);
        host_write(HPB_REG_CTRL, 32'h1);
        count_req(4, seen);
        check("go_with_err_ignored", 64'(seen), 64'd0);
        host_write(HPB_REG_CTRL, 32'h3);
        check("clr_go_req", 64'(hpb_wr_req), 64'd1);
        check("clr_go_err", 64'(hpb_err),    64'd0);
        measure(0, h, r);
        check("clr_go_req_cycles", 64'(h), 64'd1);
        host_read(HPB_REG_STATUS);
        check("clr_go_status", 64'(rd), 64'h0001_0000);

        // Address wrap at the top of the 14-bit range.
        host_write(HPB_REG_SYM_ADDR, 32'h3FFF);
        host_write(HPB_REG_CTRL, 32'h1);
        check("wrap_addr_during_req", 64'(hpb_wr_addr), 64'h3FFF);
        measure(0, h, r);
        host_read(HPB_REG_SYM_ADDR);
        check("wrap_symaddr_inc",   64'(rd),  64'h0);
        check("wrap_symaddr_noinc", 64'(rd2), 64'h3FFF);

        // Collision: payload write and GO while busy.
        host_write(4'd4, 32'h11);
        host_write(4'd5, 32'h22);
        host_write(HPB_REG_CTRL, 32'h1);
        host_write(4'd4, 32'h55);
        host_write(HPB_REG_CTRL, 32'h1);
        check("coll_data_stable", hpb_wr_data, 64'h0000_0022_0000_0011);
        check("coll_req_held", 64'(hpb_wr_req), 64'd1);
        measure(0, h, r);
        check("coll_req_cycles", 64'(h), 64'd1);
        count_req(4, seen);
        check("coll_no_second_req", 64'(seen), 64'd0);
        host_read(HPB_REG_STATUS);
        check("coll_status", 64'(rd), 64'h0003_0004);
        host_read(4'd4);
        check("coll_data0", 64'(rd), 64'h11);
        host_write(HPB_REG_CTRL, 32'h2);
        host_read(HPB_REG_STATUS);
        check("clr_coll_status", 64'(rd), 64'h0003_0000);

        // Reset on the second request cycle.
        host_write(HPB_REG_CTRL, 32'h1);
        @(posedge clk); #1;
        check("midreq_req_before", 64'(hpb_wr_req), 64'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midreq_req_dropped", 64'(hpb_wr_req), 64'd0);
        check("midreq_busy",        64'(hpb_busy),   64'd0);
        reset_n = 1'b1;
        host_read(HPB_REG_STATUS);
        check("midreq_status", 64'(rd), 64'h0);
        host_read(HPB_REG_SYM_ADDR);
        check("midreq_symaddr", 64'(rd), 64'h0);
        host_read(HPB_REG_BYTE_EN);
        check("midreq_byte_en", 64'(rd), 64'h0);
        host_read(4'd5);
        check("midreq_data1", 64'(rd), 64'h0);
        check("midreq_wr_data", hpb_wr_data, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hpb_wr_ctrl.md
# hpb_wr_ctrl

Host-side write sequencer that sits directly upstream of the symbol-parameter RAM control block. It exposes a small word-addressed register file to host software. On a GO command it drives one RAM write request (`hpb_wr_addr`, `hpb_wr_data`, `hpb_wr_en`, `hpb_wr_req`) and holds it until the RAM control block returns `rcb_wr_done` or a timeout expires. It then releases the request for one cycle, which is required before the RAM control block accepts another write.

## Interface
- `HPB_RAM_WIDTH`, 64: RAM word width. Must be a multiple of 32, range 32–128.
- `HPB_TIMEOUT`, 1024: maximum cycles `hpb_wr_req` is held waiting for done. Must be at least 2.
- `HPB_AUTO_INC`, 1: when 1, SYM_ADDR increments after each successful write.
- `clk` in 1: core clock.
- `reset_n` in 1: synchronous, active-low reset.
- `host_cs` in 1: host access strobe, one cycle per access.
- `host_we` in 1: 1 = write access, 0 = read access.
- `host_addr` in 4: register word index.
- `host_wdata` in 32: host write data.
- `host_rdata` out 32: registered read data.
- `host_rvalid` out 1: read data valid pulse.
- `hpb_wr_addr` out 14: RAM address. Equals SYM_ADDR.
- `hpb_wr_data` out HPB_RAM_WIDTH: RAM write data, formed by concatenating the DATA registers.
- `hpb_wr_en` out HPB_RAM_WIDTH/8: byte enables. Equals BYTE_EN.
- `hpb_wr_req` out 1: write request, registered.
- `rcb_wr_done` in 1: write accepted by the RAM control block, same cycle as acceptance.
- `hpb_busy` out 1: FSM is not in IDLE.
- `hpb_err` out 1: sticky timeout error.

## Operation
- **Register map:**
  - 0 CTRL (write-only): bit0 GO, bit1 CLR_ERR.
  - 1 STATUS (read-only): bit0 busy, bit1 err, bit2 collision, [31:16] wr_count.
  - 2 SYM_ADDR [13:0].
  - 3 BYTE_EN [HPB_RAM_WIDTH/8-1:0].
  - 4+i DATA_i for i < HPB_RAM_WIDTH/32. DATA_0 holds the least significant word.
- Unmapped reads return 0. Unmapped writes have no effect.
- While busy, writes to SYM_ADDR, BYTE_EN and DATA are dropped and set the sticky collision bit. The outputs therefore stay stable for the whole request, so no shadow copies are needed.
- CLR_ERR clears both err and collision.
- **FSM `hpb_state_t`:**
  - IDLE: GO with err=0 → REQ. GO with err=1 is ignored. GO while busy is ignored and sets collision.
  - REQ: `hpb_wr_req`=1 and the timer counts up. If `rcb_wr_done`=1 → REL; in the same cycle wr_count increments (16-bit, wraps at 0xFFFF→0) and, if HPB_AUTO_INC=1, SYM_ADDR increments (16383 wraps to 0). Else, if timer = HPB_TIMEOUT-1 → err set, → REL, with no count or address change.
  - REL: `hpb_wr_req`=0 for exactly one cycle, then → IDLE.
- If GO and CLR_ERR are both set in one write, CLR_ERR is applied first and the GO is accepted.
- CTRL and STATUS accesses are always allowed, including while busy.
- `rcb_wr_done` is ignored outside REQ.

## Timing
- **Reset values:** all registers are 0. `hpb_wr_req`=0, `hpb_busy`=0, `hpb_err`=0, `host_rvalid`=0, `host_rdata`=0, FSM in IDLE, timer 0.
- **Write access:** a host write in cycle N updates the register at the N+1 edge.
- **Read access:** a host read in cycle N gives `host_rdata` and a one-cycle `host_rvalid` pulse in N+1.
- **GO latency:** GO written in cycle N gives `hpb_wr_req`=1 and `hpb_busy`=1 from N+1.
- **Best case:** done in N+1 gives `hpb_wr_req`=0 (REL) in N+2 and IDLE with `hpb_busy`=0 in N+3. The shortest back-to-back write spacing is therefore 3 cycles.
- **Timeout:** the timer is 0 in the first REQ cycle. With no done, REQ lasts exactly HPB_TIMEOUT cycles, and err is visible in the cycle after the last REQ cycle.
- **Reset mid-request:** `hpb_wr_req` drops at the next edge. No count or address update occurs for the aborted request.

## Structure
- `tts_pkg` holds:
  - the `hpb_state_t` enum (IDLE, REQ, REL);
  - the register offset constants (HPB_REG_CTRL .. HPB_REG_DATA0);
  - the STATUS bit-position constants.
- Single module with no sub-modules. The register file, FSM and timeout counter are all in `hpb_wr_ctrl`.

## Test plan
- **Single write:** write SYM_ADDR=0x0123, BYTE_EN=0xFF, DATA0=0xDEADBEEF, DATA1=0x01234567, then GO; tie done=req.
  - `hpb_wr_data`=0x01234567DEADBEEF with req high for exactly 1 cycle.
  - STATUS wr_count=1 and SYM_ADDR reads back 0x0124.
- **Read-stall:** hold done=0 for 5 REQ cycles, then 1.
  - req stays high for 6 cycles, then low for 1 cycle (REL).
  - err=0.
- **Timeout:** HPB_TIMEOUT=8 and done never asserted.
  - req is high for exactly 8 cycles; STATUS then reads err=1 and wr_count=0.
  - A following GO is ignored.
  - CLR_ERR+GO in one write starts a new request.
- **Address wrap:** SYM_ADDR=16383, GO, done=req.
  - `hpb_wr_addr`=16383 during the request and SYM_ADDR=0 afterwards.
  - With HPB_AUTO_INC=0, SYM_ADDR stays 16383.
- **Collision:** write DATA0=0x55 while busy.
  - `hpb_wr_data` is unchanged and STATUS collision=1.
  - A GO while busy does not produce a second request.
- **Reset mid-REQ:** assert reset_n=0 on the 2nd REQ cycle.
  - `hpb_wr_req`=0 at the next edge; all registers and STATUS read 0.
